toy_bus_lsu_os_ctrl: RTL and testbench

- Outstanding-transaction controller between the LSU request port and the LSU 1-to-2 bus decode/ack-arbitration node.
- Gates LSU requests so each of the two downstream targets has at most MAX_OS requests in flight.
- In ORDERED mode, forbids target switching while the other target still has acks pending, so acks return in issue order.
- Provides a drain handshake and status/error outputs for the LSU pipeline flush.

---
 rtl/toy_bus_lsu_os_ctrl.sv | 135 +++++++++++++
 tb/tb_toy_bus_lsu_os_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_bus_lsu_os_ctrl.sv
// Outstanding-transaction gate between the LSU request port and the 1-to-2 bus decode node.
// Tracks in-flight requests per target, optionally enforces in-order acks, and runs a drain handshake.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no requests in flight
// BUSY0  | only target 0 has requests in flight
// BUSY1  | only target 1 has requests in flight
// BUSY01 | both targets in flight (only when ORDERED = 0)
// DRAIN  | drain_req seen; issue blocked, waiting for acks to return
module toy_bus_lsu_os_ctrl #(
   parameter int unsigned MAX_OS  = 4,
   parameter logic [3:0]  T1_ID   = 4'd1,
   parameter bit          ORDERED = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_req_vld,
   output logic         in_req_rdy,
   input  logic [3:0]   in_req_tgt_id,
   input  logic [356:0] in_req_pld,
   output logic         out_req_vld,
   input  logic         out_req_rdy,
   output logic [3:0]   out_req_tgt_id,
   output logic [356:0] out_req_pld,
   input  logic         in_ack_vld,
   output logic         in_ack_rdy,
   input  logic [3:0]   in_ack_src_id,
   input  logic [292:0] in_ack_pld,
   output logic         out_ack_vld,
   input  logic         out_ack_rdy,
   output logic [3:0]   out_ack_src_id,
   output logic [292:0] out_ack_pld,
   input  logic         drain_req,
   output logic         drain_done,
   output logic [3:0]   os_cnt0,
   output logic [3:0]   os_cnt1,
   output logic         err_underflow
);

   typedef enum logic [2:0] {IDLE, BUSY0, BUSY1, BUSY01, DRAIN} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_OS);

   state_t     state;
   logic [3:0] cnt0;
   logic [3:0] cnt1;
   logic       err;

   logic       req_t1;
   logic       ack_t1;
   logic [3:0] cnt_t;
   logic [3:0] cnt_other;
   logic       en;
   logic       ih;
   logic       ah;
   logic       inc0;
   logic       inc1;
   logic       dec0;
   logic       dec1;
   logic       underflow;
   logic [3:0] cnt0_nxt;
   logic [3:0] cnt1_nxt;

   // Same-counter issue and ack cancel; an ack against an empty counter saturates at 0.
   function automatic logic [3:0] cnt_upd(input logic [3:0] c, input logic inc, input logic dec);
      logic [3:0] r;
      r = c;
      if (inc && !dec)
         r = c + 4'd1;
      else if (dec && !inc && c != 4'd0)
         r = c - 4'd1;
      return r;
   endfunction

   assign req_t1    = (in_req_tgt_id == T1_ID);
   assign ack_t1    = (in_ack_src_id == T1_ID);
   assign cnt_t     = req_t1 ? cnt1 : cnt0;
   assign cnt_other = req_t1 ? cnt0 : cnt1;

   assign en = (state != DRAIN) && !drain_req && (cnt_t < MAX_CNT) &&
               (!ORDERED || cnt_other == 4'd0);

   assign out_req_vld    = in_req_vld && en;
   assign in_req_rdy     = out_req_rdy && en;
   assign out_req_tgt_id = in_req_tgt_id;
   assign out_req_pld    = in_req_pld;

   assign out_ack_vld    = in_ack_vld;
   assign in_ack_rdy     = out_ack_rdy;
   assign out_ack_src_id = in_ack_src_id;
   assign out_ack_pld    = in_ack_pld;

   assign ih   = in_req_vld && in_req_rdy;
   assign ah   = in_ack_vld && out_ack_rdy;
   assign inc0 = ih && !req_t1;
   assign inc1 = ih && req_t1;
   assign dec0 = ah && !ack_t1;
   assign dec1 = ah && ack_t1;

   assign underflow = (dec0 && cnt0 == 4'd0) || (dec1 && cnt1 == 4'd0);
   assign cnt0_nxt  = cnt_upd(cnt0, inc0, dec0);
   assign cnt1_nxt  = cnt_upd(cnt1, inc1, dec1);

   assign drain_done    = (state == DRAIN) && (cnt0 == 4'd0) && (cnt1 == 4'd0);
   assign os_cnt0       = cnt0;
   assign os_cnt1       = cnt1;
   assign err_underflow = err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt0  <= 4'd0;
         cnt1  <= 4'd0;
         err   <= 1'b0;
      end else begin
         cnt0 <= cnt0_nxt;
         cnt1 <= cnt1_nxt;
         if (underflow)
            err <= 1'b1;
         // State follows the post-update counts so it never lags the counters.
         if (drain_req)
            state <= DRAIN;
         else if (cnt0_nxt != 4'd0 && cnt1_nxt != 4'd0)
            state <= BUSY01;
         else if (cnt0_nxt != 4'd0)
            state <= BUSY0;
         else if (cnt1_nxt != 4'd0)
            state <= BUSY1;
         else
            state <= IDLE;
      end
   end

endmodule

// File: tb/tb_toy_bus_lsu_os_ctrl.sv
// Directed bench for toy_bus_lsu_os_ctrl: one ORDERED=1 and one ORDERED=0 instance share stimulus.
module tb_toy_bus_lsu_os_ctrl;

   logic         clk;
   logic         rst_n;
   logic         req_vld;
   logic [3:0]   req_tgt;
   logic [356:0] req_pld;
   logic         out_req_rdy;
   logic         ack_vld;
   logic [3:0]   ack_src;
   logic [292:0] ack_pld;
   logic         out_ack_rdy;
   logic         drain_req;

   logic         o_in_req_rdy, o_out_req_vld, o_in_ack_rdy, o_out_ack_vld, o_drain_done, o_err;
   logic [3:0]   o_out_req_tgt, o_out_ack_src, o_cnt0, o_cnt1;
   logic [356:0] o_out_req_pld;
   logic [292:0] o_out_ack_pld;

   logic         u_in_req_rdy, u_out_req_vld, u_in_ack_rdy, u_out_ack_vld, u_drain_done, u_err;
   logic [3:0]   u_out_req_tgt, u_out_ack_src, u_cnt0, u_cnt1;
   logic [356:0] u_out_req_pld;
   logic [292:0] u_out_ack_pld;

   int total = 0;
   int bad   = 0;

   toy_bus_lsu_os_ctrl #(.MAX_OS(4), .T1_ID(4'd1), .ORDERED(1'b1)) u_ord (
      .clk(clk), .rst_n(rst_n),
      .in_req_vld(req_vld), .in_req_rdy(o_in_req_rdy), .in_req_tgt_id(req_tgt), .in_req_pld(req_pld),
      .out_req_vld(o_out_req_vld), .out_req_rdy(out_req_rdy), .out_req_tgt_id(o_out_req_tgt),
      .out_req_pld(o_out_req_pld),
      .in_ack_vld(ack_vld), .in_ack_rdy(o_in_ack_rdy), .in_ack_src_id(ack_src), .in_ack_pld(ack_pld),
      .out_ack_vld(o_out_ack_vld), .out_ack_rdy(out_ack_rdy), .out_ack_src_id(o_out_ack_src),
      .out_ack_pld(o_out_ack_pld),
      .drain_req(drain_req), .drain_done(o_drain_done),
      .os_cnt0(o_cnt0), .os_cnt1(o_cnt1), .err_underflow(o_err)
   );

   toy_bus_lsu_os_ctrl #(.MAX_OS(4), .T1_ID(4'd1), .ORDERED(1'b0)) u_unord (
      .clk(clk), .rst_n(rst_n),
      .in_req_vld(req_vld), .in_req_rdy(u_in_req_rdy), .in_req_tgt_id(req_tgt), .in_req_pld(req_pld),
      .out_req_vld(u_out_req_vld), .out_req_rdy(out_req_rdy), .out_req_tgt_id(u_out_req_tgt),
      .out_req_pld(u_out_req_pld),
      .in_ack_vld(ack_vld), .in_ack_rdy(u_in_ack_rdy), .in_ack_src_id(ack_src), .in_ack_pld(ack_pld),
      .out_ack_vld(u_out_ack_vld), .out_ack_rdy(out_ack_rdy), .out_ack_src_id(u_out_ack_src),
      .out_ack_pld(u_out_ack_pld),
      .drain_req(drain_req), .drain_done(u_drain_done),
      .os_cnt0(u_cnt0), .os_cnt1(u_cnt1), .err_underflow(u_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_vld     = 1'b0;
      req_tgt     = 4'd0;
      out_req_rdy = 1'b1;
      ack_vld     = 1'b0;
      ack_src     = 4'd0;
      out_ack_rdy = 1'b1;
      drain_req   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      total++; if (o_cnt0 !== 4'd0) begin bad++; $display("FAIL reset_cnt0 got=%0d exp=0", o_cnt0); end
      total++; if (o_cnt1 !== 4'd0) begin bad++; $display("FAIL reset_cnt1 got=%0d exp=0", o_cnt1); end
      total++; if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", o_err); end
      total++; if (o_drain_done !== 1'b0) begin bad++; $display("FAIL reset_drain_done got=%b exp=0", o_drain_done); end
      total++; if (o_in_req_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_req_rdy got=%b exp=1", o_in_req_rdy); end
      total++; if (o_out_req_vld !== 1'b0) begin bad++; $display("FAIL reset_out_req_vld got=%b exp=0", o_out_req_vld); end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_max_os();
      do_reset();
      req_vld = 1'b1;
      req_tgt = 4'd0;
      req_pld = {5'h15, {11{32'hA5C3_0F1E}}};
      #1;
      total++; if (o_out_req_pld !== {5'h15, {11{32'hA5C3_0F1E}}}) begin bad++; $display("FAIL req_pld_pass got=%h", o_out_req_pld); end
      total++; if (o_out_req_tgt !== 4'd0) begin bad++; $display("FAIL req_tgt_pass got=%0d exp=0", o_out_req_tgt); end
      for (int i = 0; i < 4; i++) begin
         total++; if (o_in_req_rdy !== 1'b1) begin bad++; $display("FAIL max_os_rdy%0d got=%b exp=1", i, o_in_req_rdy); end
         tick();
      end
      total++; if (o_cnt0 !== 4'd4) begin bad++; $display("FAIL max_os_cnt0 got=%0d exp=4", o_cnt0); end
      total++; if (o_in_req_rdy !== 1'b0) begin bad++; $display("FAIL max_os_5th_rdy got=%b exp=0", o_in_req_rdy); end
      total++; if (o_out_req_vld !== 1'b0) begin bad++; $display("FAIL max_os_5th_vld got=%b exp=0", o_out_req_vld); end
      ack_vld = 1'b1;
      ack_src = 4'd0;
      tick();
      ack_vld = 1'b0;
      #1;
      total++; if (o_cnt0 !== 4'd3) begin bad++; $display("FAIL max_os_after_ack got=%0d exp=3", o_cnt0); end
      total++; if (o_in_req_rdy !== 1'b1) begin bad++; $display("FAIL max_os_5th_go got=%b exp=1", o_in_req_rdy); end
      tick();
      req_vld = 1'b0;
      total++; if (o_cnt0 !== 4'd4) begin bad++; $display("FAIL max_os_refill got=%0d exp=4", o_cnt0); end
   endtask

   task automatic test_ordered();
      do_reset();
      req_vld = 1'b1;
      req_tgt = 4'd0;
      tick();
      tick();
      req_tgt = 4'd1;
      #1;
      total++; if (o_in_req_rdy !== 1'b0) begin bad++; $display("FAIL ord_switch_rdy got=%b exp=0", o_in_req_rdy); end
      total++; if (o_out_req_vld !== 1'b0) begin bad++; $display("FAIL ord_switch_vld got=%b exp=0", o_out_req_vld); end
      total++; if (u_in_req_rdy !== 1'b1) begin bad++; $display("FAIL unord_switch_rdy got=%b exp=1", u_in_req_rdy); end
      tick();
      total++; if (u_cnt0 !== 4'd2) begin bad++; $display("FAIL unord_cnt0 got=%0d exp=2", u_cnt0); end
      total++; if (u_cnt1 !== 4'd1) begin bad++; $display("FAIL unord_cnt1 got=%0d exp=1", u_cnt1); end
      ack_vld = 1'b1;
      ack_src = 4'd0;
      tick();
      total++; if (o_cnt0 !== 4'd1) begin bad++; $display("FAIL ord_ack1_cnt0 got=%0d exp=1", o_cnt0); end
      total++; if (o_in_req_rdy !== 1'b0) begin bad++; $display("FAIL ord_still_stall got=%b exp=0", o_in_req_rdy); end
      tick();
      ack_vld = 1'b0;
      #1;
      total++; if (o_cnt0 !== 4'd0) begin bad++; $display("FAIL ord_ack2_cnt0 got=%0d exp=0", o_cnt0); end
      total++; if (o_in_req_rdy !== 1'b1) begin bad++; $display("FAIL ord_release_rdy got=%b exp=1", o_in_req_rdy); end
      tick();
      req_vld = 1'b0;
      total++; if (o_cnt1 !== 4'd1) begin bad++; $display("FAIL ord_cnt1 got=%0d exp=1", o_cnt1); end
      total++; if (o_cnt0 !== 4'd0) begin bad++; $display("FAIL ord_cnt0_end got=%0d exp=0", o_cnt0); end
   endtask

   task automatic test_same_cycle();
      do_reset();
      req_vld = 1'b1;
      req_tgt = 4'd0;
      tick();
      tick();
      ack_vld = 1'b1;
      ack_src = 4'd0;
      tick();
      total++; if (u_cnt0 !== 4'd2) begin bad++; $display("FAIL same_ctr_cnt0 got=%0d exp=2", u_cnt0); end
      total++; if (o_cnt0 !== 4'd2) begin bad++; $display("FAIL same_ctr_ord_cnt0 got=%0d exp=2", o_cnt0); end
      ack_vld = 1'b0;
      req_tgt = 4'd1;
      tick();
      total++; if (u_cnt1 !== 4'd1) begin bad++; $display("FAIL diff_setup_cnt1 got=%0d exp=1", u_cnt1); end
      req_tgt = 4'd0;
      ack_vld = 1'b1;
      ack_src = 4'd1;
      tick();
      req_vld = 1'b0;
      ack_vld = 1'b0;
      total++; if (u_cnt0 !== 4'd3) begin bad++; $display("FAIL diff_ctr_cnt0 got=%0d exp=3", u_cnt0); end
      total++; if (u_cnt1 !== 4'd0) begin bad++; $display("FAIL diff_ctr_cnt1 got=%0d exp=0", u_cnt1); end
      total++; if (u_err !== 1'b0) begin bad++; $display("FAIL diff_ctr_err got=%b exp=0", u_err); end
   endtask

   task automatic test_drain();
      do_reset();
      req_vld = 1'b1;
      req_tgt = 4'd0;
      tick();
      tick();
      tick();
      drain_req = 1'b1;
      #1;
      total++; if (o_out_req_vld !== 1'b0) begin bad++; $display("FAIL drain_vld_mask got=%b exp=0", o_out_req_vld); end
      total++; if (o_in_req_rdy !== 1'b0) begin bad++; $display("FAIL drain_rdy_mask got=%b exp=0", o_in_req_rdy); end
      tick();
      total++; if (o_cnt0 !== 4'd3) begin bad++; $display("FAIL drain_no_issue got=%0d exp=3", o_cnt0); end
      total++; if (o_drain_done !== 1'b0) begin bad++; $display("FAIL drain_done_early got=%b exp=0", o_drain_done); end
      ack_vld = 1'b1;
      ack_src = 4'd0;
      tick();
      total++; if (o_cnt0 !== 4'd2) begin bad++; $display("FAIL drain_ack1 got=%0d exp=2", o_cnt0); end
      out_ack_rdy = 1'b0;
      #1;
      total++; if (o_in_ack_rdy !== 1'b0) begin bad++; $display("FAIL drain_ack_rdy_pass got=%b exp=0", o_in_ack_rdy); end
      tick();
      total++; if (o_cnt0 !== 4'd2) begin bad++; $display("FAIL drain_stalled_ack got=%0d exp=2", o_cnt0); end
      out_ack_rdy = 1'b1;
      tick();
      total++; if (o_drain_done !== 1'b0) begin bad++; $display("FAIL drain_done_at1 got=%b exp=0", o_drain_done); end
      tick();
      ack_vld = 1'b0;
      total++; if (o_cnt0 !== 4'd0) begin bad++; $display("FAIL drain_cnt0_zero got=%0d exp=0", o_cnt0); end
      total++; if (o_drain_done !== 1'b1) begin bad++; $display("FAIL drain_done got=%b exp=1", o_drain_done); end
      drain_req = 1'b0;
      tick();
      total++; if (o_drain_done !== 1'b0) begin bad++; $display("FAIL drain_exit_done got=%b exp=0", o_drain_done); end
      total++; if (o_in_req_rdy !== 1'b1) begin bad++; $display("FAIL drain_resume_rdy got=%b exp=1", o_in_req_rdy); end
      tick();
      req_vld = 1'b0;
      total++; if (o_cnt0 !== 4'd1) begin bad++; $display("FAIL drain_resume_cnt0 got=%0d exp=1", o_cnt0); end
   endtask

   task automatic test_underflow();
      do_reset();
      ack_vld = 1'b1;
      ack_src = 4'd1;
      ack_pld = {5'h0B, {9{32'h1234_5678}}};
      #1;
      total++; if (o_out_ack_vld !== 1'b1) begin bad++; $display("FAIL uf_ack_vld got=%b exp=1", o_out_ack_vld); end
      total++; if (o_out_ack_src !== 4'd1) begin bad++; $display("FAIL uf_ack_src got=%0d exp=1", o_out_ack_src); end
      total++; if (o_out_ack_pld !== {5'h0B, {9{32'h1234_5678}}}) begin bad++; $display("FAIL uf_ack_pld got=%h", o_out_ack_pld); end
      tick();
      ack_vld = 1'b0;
      total++; if (o_err !== 1'b1) begin bad++; $display("FAIL uf_err_set got=%b exp=1", o_err); end
      total++; if (o_cnt1 !== 4'd0) begin bad++; $display("FAIL uf_cnt1 got=%0d exp=0", o_cnt1); end
      tick();
      tick();
      total++; if (o_err !== 1'b1) begin bad++; $display("FAIL uf_err_sticky got=%b exp=1", o_err); end
   endtask

   task automatic test_async_reset();
      do_reset();
      req_vld = 1'b1;
      req_tgt = 4'd0;
      tick();
      tick();
      req_vld = 1'b0;
      total++; if (o_cnt0 !== 4'd2) begin bad++; $display("FAIL ar_setup got=%0d exp=2", o_cnt0); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (o_cnt0 !== 4'd0) begin bad++; $display("FAIL ar_cnt0 got=%0d exp=0", o_cnt0); end
      total++; if (o_drain_done !== 1'b0) begin bad++; $display("FAIL ar_drain_done got=%b exp=0", o_drain_done); end
      tick();
      rst_n = 1'b1;
      req_vld = 1'b1;
      #1;
      total++; if (o_in_req_rdy !== 1'b1) begin bad++; $display("FAIL ar_first_rdy got=%b exp=1", o_in_req_rdy); end
      tick();
      req_vld = 1'b0;
      total++; if (o_cnt0 !== 4'd1) begin bad++; $display("FAIL ar_first_cnt0 got=%0d exp=1", o_cnt0); end
      ack_vld = 1'b1;
      ack_src = 4'd1;
      tick();
      ack_vld = 1'b0;
      total++; if (o_err !== 1'b1) begin bad++; $display("FAIL ar_late_ack_err got=%b exp=1", o_err); end
   endtask

   initial begin
      req_pld = '0;
      ack_pld = '0;
      test_reset();
      test_max_os();
      test_ordered();
      test_same_cycle();
      test_drain();
      test_underflow();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
